// File: rtl/serial_frame_rx.sv
// serial_frame_rx: one-sample-per-clock receiver for start/data/parity/stop frames.
// Data bits arrive LSB-first. A completed frame is presented on a valid/ready register,
// together with its parity status. Frames that complete while the output is full are
// dropped and reported through a sticky overrun flag.
module serial_frame_rx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 2,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 rx_ready,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic [CNT_W-1:0]     frame_cnt
);

    localparam int unsigned    BCW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);
    // Two stop bits at most, so one counter bit is enough.
    localparam logic           LAST_STOP = (STOP_BITS > 1);
    localparam logic           PAR_EN    = (PARITY_EN != 0);
    localparam logic           PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } state_e;

    // Receiver state
    state_e                 r_state;
    state_e                 w_state_d;
    logic [BCW-1:0]         r_bit_cnt;
    logic [BCW-1:0]         w_bit_cnt_d;
    logic                   r_stop_cnt;
    logic                   w_stop_cnt_d;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   w_shift_d;
    logic                   r_par_bit;
    logic                   w_par_bit_d;

    // Output registers
    logic [DATA_BITS-1:0]   r_rx_data;
    logic [DATA_BITS-1:0]   w_rx_data_d;
    logic                   r_rx_valid;
    logic                   w_rx_valid_d;
    logic                   r_parity_err;
    logic                   w_parity_err_d;
    logic                   r_frame_err;
    logic                   w_frame_err_d;
    logic                   r_overrun;
    logic                   w_overrun_d;
    logic [CNT_W-1:0]       r_frame_cnt;
    logic [CNT_W-1:0]       w_frame_cnt_d;

    // Frame events decoded from the current state and line sample
    logic                   w_complete;
    logic                   w_abort;
    logic                   w_par_xor;
    logic                   w_par_mismatch;
    logic                   w_load;
    logic                   w_drop;

    // State register plus all output registers; reset discards any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_bit_cnt    <= '0;
            r_stop_cnt   <= 1'b0;
            r_shift      <= '0;
            r_par_bit    <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_state      <= w_state_d;
            r_bit_cnt    <= w_bit_cnt_d;
            r_stop_cnt   <= w_stop_cnt_d;
            r_shift      <= w_shift_d;
            r_par_bit    <= w_par_bit_d;
            r_rx_data    <= w_rx_data_d;
            r_rx_valid   <= w_rx_valid_d;
            r_parity_err <= w_parity_err_d;
            r_frame_err  <= w_frame_err_d;
            r_overrun    <= w_overrun_d;
            r_frame_cnt  <= w_frame_cnt_d;
        end
    end

    // Frame sequencing: start detect, data capture, parity capture, stop checking.
    always_comb begin
        w_state_d    = r_state;
        w_bit_cnt_d  = r_bit_cnt;
        w_stop_cnt_d = r_stop_cnt;
        w_shift_d    = r_shift;
        w_par_bit_d  = r_par_bit;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!serial_in) begin
                    w_state_d   = StData;
                    w_bit_cnt_d = '0;
                end
            end
            StData: begin
                w_shift_d[r_bit_cnt] = serial_in;
                if (r_bit_cnt == LAST_BIT) begin
                    if (PAR_EN) begin
                        w_state_d = StParity;
                    end else begin
                        w_state_d    = StStop;
                        w_stop_cnt_d = 1'b0;
                    end
                end else begin
                    w_bit_cnt_d = r_bit_cnt + BCW'(1);
                end
            end
            StParity: begin
                w_par_bit_d  = serial_in;
                w_state_d    = StStop;
                w_stop_cnt_d = 1'b0;
            end
            StStop: begin
                if (serial_in) begin
                    if (r_stop_cnt == LAST_STOP) begin
                        w_complete = 1'b1;
                        w_state_d  = StIdle;
                    end else begin
                        w_stop_cnt_d = 1'b1;
                    end
                end else begin
                    // A low stop bit kills the frame; that low is not a new start bit.
                    w_abort   = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Parity check over the captured data and parity bit.
    always_comb begin
        w_par_xor      = (^r_shift) ^ (PAR_EN & r_par_bit);
        w_par_mismatch = PAR_EN & (w_par_xor != PAR_ODD);
    end

    // Output register update: load, hand-off, overrun and frame counting.
    always_comb begin
        w_load         = w_complete & (~r_rx_valid | rx_ready);
        w_drop         = w_complete & r_rx_valid & ~rx_ready;
        w_rx_data_d    = r_rx_data;
        w_rx_valid_d   = r_rx_valid;
        w_parity_err_d = r_parity_err;
        w_frame_cnt_d  = r_frame_cnt;
        w_overrun_d    = r_overrun;
        w_frame_err_d  = w_abort;
        if (w_load) begin
            w_rx_data_d    = r_shift;
            w_rx_valid_d   = 1'b1;
            w_parity_err_d = w_par_mismatch;
            w_frame_cnt_d  = r_frame_cnt + CNT_W'(1);
        end else if (r_rx_valid && rx_ready) begin
            w_rx_valid_d = 1'b0;
        end
        // A new overrun beats a simultaneous clear.
        if (w_drop) begin
            w_overrun_d = 1'b1;
        end else if (err_clr) begin
            w_overrun_d = 1'b0;
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign frame_cnt  = r_frame_cnt;

endmodule
